// File: rtl/ram_gbuf_pkg.sv
// Shared width helpers for the banked global buffer.
// Optional byte-mask support is selected by the macro RAM_GBUF_WMASK_EN.
package ram_gbuf_pkg;

    function automatic int unsigned bank_idx_width(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned row_width(input int unsigned depth_bit);
        return depth_bit;
    endfunction

    function automatic int unsigned mask_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_gbuf_sp_bank.sv
// Single-port synchronous SRAM bank: one access per cycle, one-cycle read latency.
// Byte-masked writes when RAM_GBUF_WMASK_EN is defined, full-word writes otherwise.
module ram_gbuf_sp_bank
    import ram_gbuf_pkg::*;
#(
    parameter int unsigned DepthBit = 8,
    parameter int unsigned Width    = 96
) (
    input  logic                          clk,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [DepthBit-1:0]           addr_i,
    input  logic [Width-1:0]              wdata_i,
    input  logic [mask_width(Width)-1:0]  wmask_i,
    output logic [Width-1:0]              rdata_o
);
    localparam int unsigned MaskW = mask_width(Width);

    logic [Width-1:0] mem_q [2**DepthBit];

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
`ifdef RAM_GBUF_WMASK_EN
            for (int b = 0; b < MaskW; b++) begin
                if (wmask_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
`else
            mem_q[addr_i] <= wdata_i;
`endif
        end else if (en_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

`ifndef RAM_GBUF_WMASK_EN
    logic unused_wmask;
    assign unused_wmask = ^wmask_i;
`endif

endmodule

// File: rtl/ram_gbuf_bank_wrap.sv
// Banked global buffer: write-priority arbiter with read starvation guard,
// single-port banks, read mux and hold register. Byte mask via RAM_GBUF_WMASK_EN.
module ram_gbuf_bank_wrap
    import ram_gbuf_pkg::*;
#(
    parameter int unsigned SRAM_DEPTH_BIT = 8,
    parameter int unsigned SRAM_WIDTH     = 96,
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned MAX_RD_STALL   = 2
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               wr_req,
    output logic                                               wr_ready,
    input  logic [SRAM_DEPTH_BIT+bank_idx_width(NUM_BANKS)-1:0] addr_w,
    input  logic [SRAM_WIDTH-1:0]                              data_in,
    input  logic [mask_width(SRAM_WIDTH)-1:0]                  wr_mask,
    input  logic                                               rd_req,
    output logic                                               rd_ready,
    input  logic [SRAM_DEPTH_BIT+bank_idx_width(NUM_BANKS)-1:0] addr_r,
    output logic                                               rd_valid,
    output logic [SRAM_WIDTH-1:0]                              data_out,
    output logic [15:0]                                        conflict_cnt
);
    localparam int unsigned BankW  = bank_idx_width(NUM_BANKS);
    localparam int unsigned RowW   = row_width(SRAM_DEPTH_BIT);
    localparam int unsigned StallW = $clog2(MAX_RD_STALL + 1);

    logic [BankW-1:0]      bank_w, bank_r;
    logic [RowW-1:0]       row_w, row_r;
    logic                  conflict, read_wins;
    logic [StallW-1:0]     stall_q, stall_d;
    logic [15:0]           cnt_q;
    logic                  rd_valid_q;
    logic [BankW-1:0]      rd_bank_q;
    logic [SRAM_WIDTH-1:0] hold_q;
    logic [SRAM_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign bank_w = addr_w[BankW-1:0];
    assign bank_r = addr_r[BankW-1:0];
    assign row_w  = addr_w[BankW +: RowW];
    assign row_r  = addr_r[BankW +: RowW];

    // Writes win a same-bank clash unless the read has already stalled MAX_RD_STALL times.
    always_comb begin
        conflict  = wr_req && rd_req && (bank_w == bank_r);
        read_wins = conflict && (stall_q == StallW'(MAX_RD_STALL));
        wr_ready  = rst_n && wr_req && !read_wins;
        rd_ready  = rst_n && rd_req && (!conflict || read_wins);
        stall_d   = stall_q;
        if (!rd_req || rd_ready) begin
            stall_d = '0;
        end else if (conflict) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            hold_q     <= '0;
        end else begin
            stall_q    <= stall_d;
            rd_valid_q <= rd_ready;
            if (conflict && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (rd_ready) begin
                rd_bank_q <= bank_r;
            end
            if (rd_valid_q) begin
                hold_q <= bank_rdata[rd_bank_q];
            end
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic wr_sel, rd_sel;
        assign wr_sel = wr_ready && (bank_w == BankW'(i));
        assign rd_sel = rd_ready && (bank_r == BankW'(i));

        ram_gbuf_sp_bank #(
            .DepthBit (RowW),
            .Width    (SRAM_WIDTH)
        ) u_bank (
            .clk     (clk),
            .en_i    (wr_sel || rd_sel),
            .we_i    (wr_sel),
            .addr_i  (wr_sel ? row_w : row_r),
            .wdata_i (data_in),
            .wmask_i (wr_mask),
            .rdata_o (bank_rdata[i])
        );
    end

    assign rd_valid     = rd_valid_q;
    assign data_out     = rd_valid_q ? bank_rdata[rd_bank_q] : hold_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_gbuf_bank_wrap.sv
// Directed bench for ram_gbuf_bank_wrap: per-cycle comparison against a flat-memory
// model plus literal spot checks. Define RAM_GBUF_WMASK_EN for the masked build.
module tb_ram_gbuf_bank_wrap;
    localparam int AW = 10;
    localparam int DW = 96;
    localparam int MW = 12;
    localparam int NB = 4;
    localparam int MAXS = 2;

    logic          clk, rst_n;
    logic          wr_req, wr_ready, rd_req, rd_ready, rd_valid;
    logic [AW-1:0] addr_w, addr_r;
    logic [DW-1:0] data_in, data_out;
    logic [MW-1:0] wr_mask;
    logic [15:0]   conflict_cnt;

    int vectors = 0;
    int miscompares = 0;

    ram_gbuf_bank_wrap #(
        .SRAM_DEPTH_BIT (8),
        .SRAM_WIDTH     (DW),
        .NUM_BANKS      (NB),
        .MAX_RD_STALL   (MAXS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .wr_ready     (wr_ready),
        .addr_w       (addr_w),
        .data_in      (data_in),
        .wr_mask      (wr_mask),
        .rd_req       (rd_req),
        .rd_ready     (rd_ready),
        .addr_r       (addr_r),
        .rd_valid     (rd_valid),
        .data_out     (data_out),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flat word-addressed memory, bank = address modulo NB.
    logic [DW-1:0] m_mem [1 << AW];
    logic [DW-1:0] m_hold, m_pend_data;
    bit            m_pend;
    int            m_stall, m_cnt;

    initial begin
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        m_hold = '0; m_pend_data = '0; m_pend = 0; m_stall = 0; m_cnt = 0;
    end

    always @(negedge clk) begin
        bit clash, rwin, e_wr, e_rd;
        if (!rst_n) begin
            chk("m_rst_wr_ready", wr_ready, 0);
            chk("m_rst_rd_ready", rd_ready, 0);
            chk("m_rst_rd_valid", rd_valid, 0);
            chk("m_rst_data_out", data_out, 0);
            chk("m_rst_cnt", conflict_cnt, 0);
            m_hold = '0; m_pend = 0; m_stall = 0; m_cnt = 0;
        end else begin
            if (m_pend) m_hold = m_pend_data;
            chk("m_rd_valid", rd_valid, m_pend);
            chk("m_data_out", data_out, m_hold);
            chk("m_conflict_cnt", conflict_cnt, m_cnt);
            clash = wr_req && rd_req && ((addr_w % NB) == (addr_r % NB));
            rwin  = clash && (m_stall == MAXS);
            e_wr  = wr_req && !rwin;
            e_rd  = rd_req && (!clash || rwin);
            chk("m_wr_ready", wr_ready, e_wr);
            chk("m_rd_ready", rd_ready, e_rd);
            m_pend = e_rd;
            if (e_rd) m_pend_data = m_mem[addr_r];
            if (e_wr) begin
`ifdef RAM_GBUF_WMASK_EN
                for (int b = 0; b < MW; b++)
                    if (wr_mask[b]) m_mem[addr_w][b*8 +: 8] = data_in[b*8 +: 8];
`else
                m_mem[addr_w] = data_in;
`endif
            end
            if (clash && m_cnt < 65535) m_cnt++;
            m_stall = (!rd_req || e_rd) ? 0 : m_stall + 1;
        end
    end

    task automatic drive(input bit wr, input logic [AW-1:0] aw, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input bit rd, input logic [AW-1:0] ar);
        wr_req = wr; addr_w = aw; data_in = d; wr_mask = m; rd_req = rd; addr_r = ar;
    endtask

    task automatic idle();
        drive(0, '0, '0, '0, 0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        drive(1, a, d, m, 0, '0);
        step();
        idle();
    endtask

    localparam logic [DW-1:0] DA = 96'h0102_0304_0506_0708_090A_0B0C;
    localparam logic [DW-1:0] DB = 96'hBBBB_0000_1111_2222_3333_4444;
    localparam logic [DW-1:0] DC = 96'hCCCC_5555_6666_7777_8888_9999;

    initial begin
        logic [3:0]    pat_rd, pat_wr;
        logic [DW-1:0] exp_mask;
        pat_rd = 4'b0100;  // 0,0,1,0 from cycle 0
        pat_wr = 4'b1011;  // 1,1,0,1 from cycle 0
`ifdef RAM_GBUF_WMASK_EN
        exp_mask = {{88{1'b1}}, 8'h00};
`else
        exp_mask = '0;
`endif
        rst_n = 1'b0;
        drive(1, 10'h001, '1, '1, 1, 10'h002);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_cnt", conflict_cnt, 0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        wr(10'h002, DA, '1);
        wr(10'h003, DC, '1);
        wr(10'h007, DB, '1);

        // Parallel access to banks 1 and 2
        drive(1, 10'h005, {12{8'hA5}}, '1, 1, 10'h002);
        #1;
        chk("par_wr_ready", wr_ready, 1);
        chk("par_rd_ready", rd_ready, 1);
        step();
        idle();
        #1;
        chk("par_rd_valid", rd_valid, 1);
        chk("par_data", data_out, DA);

        // Single conflict on bank 3
        step();
        drive(1, 10'h00B, 96'hEE, '1, 1, 10'h003);
        #1;
        chk("cf_rd_ready", rd_ready, 0);
        chk("cf_wr_ready", wr_ready, 1);
        step();
        drive(0, '0, '0, '0, 1, 10'h003);
        #1;
        chk("cf_cnt", conflict_cnt, 1);
        chk("cf_rd_retry", rd_ready, 1);
        step();
        idle();
        #1;
        chk("cf_data", data_out, DC);

        // Starvation guard: both held to bank 3 for four cycles
        step();
        drive(1, 10'h00F, 96'hFF00, '1, 1, 10'h007);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("sv_rd_ready", rd_ready, pat_rd[i]);
            chk("sv_wr_ready", wr_ready, pat_wr[i]);
            step();
        end
        idle();
        #1;
        chk("sv_cnt", conflict_cnt, 5);
        chk("sv_data", data_out, DB);
        step();

        // Byte mask
        wr(10'h010, '1, '1);
        wr(10'h010, '0, 12'h001);
        drive(0, '0, '0, '0, 1, 10'h010);
        step();
        idle();
        #1;
        chk("mask_data", data_out, exp_mask);
        step();

        // Hold and reset
        wr(10'h021, 96'h1234, '1);
        drive(0, '0, '0, '0, 1, 10'h021);
        step();
        idle();
        #1;
        chk("hold_first", data_out, 96'h1234);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", rd_valid, 0);
            chk("hold_data", data_out, 96'h1234);
        end
        drive(0, '0, '0, '0, 1, 10'h010);
        step();
        rst_n = 1'b0;
        idle();
        #1;
        chk("rstf_data", data_out, 0);
        chk("rstf_valid", rd_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstf_after_valid", rd_valid, 0);
        chk("rstf_after_data", data_out, 0);
        drive(0, '0, '0, '0, 1, 10'h021);
        step();
        idle();
        #1;
        chk("rstf_mem_valid", rd_valid, 1);
        chk("rstf_mem_data", data_out, 96'h1234);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_gbuf_bank_wrap.md
RAM_GBUF_BANK_WRAP -- requirements
Module: ram_gbuf_bank_wrap

Interface
REQ-001 SHALL have parameter SRAM_DEPTH_BIT, default 8: address bits per bank.
REQ-002 SHALL have parameter SRAM_WIDTH, default 96: data width in bits, a multiple of 8.
REQ-003 SHALL have parameter NUM_BANKS, default 4: bank count, power of 2, at least 2.
REQ-004 SHALL have parameter MAX_RD_STALL, default 2: consecutive read stalls tolerated before the read wins, at least 1.
REQ-005 SHALL have ports in this order:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_req  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- addr_w  in  SRAM_DEPTH_BIT+log2(NUM_BANKS)  write address; low log2(NUM_BANKS) bits select the bank.
- data_in  in  SRAM_WIDTH  write data.
- wr_mask  in  SRAM_WIDTH/8  byte enables, 1 = write that byte.
- rd_req  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- addr_r  in  same width as addr_w  read address.
- rd_valid  out  1  data_out is fresh this cycle.
- data_out  out  SRAM_WIDTH  read data, held between reads.
- conflict_cnt  out  16  saturating count of same-bank conflicts.

Function
REQ-006 SHALL map each address to bank = addr[log2(NUM_BANKS)-1:0] and row = the remaining upper bits.
REQ-007 SHALL model every bank as single-port: at most one access, read or write, per bank per cycle.
REQ-008 SHALL, when the read and write target different banks, or only one request is present, accept both; wr_ready and rd_ready equal the corresponding req.
REQ-009 SHALL treat wr_req and rd_req to the same bank in one cycle as a conflict, resolved by write priority: wr_ready=1, rd_ready=0.
REQ-010 SHALL keep a read-stall counter with this behaviour:
- increments on each conflict-stalled read;
- resets to 0 whenever a read is accepted or rd_req is low;
- when the counter equals MAX_RD_STALL, the next conflict gives the read priority: rd_ready=1, wr_ready=0.
REQ-011 SHALL compute wr_ready and rd_ready combinationally from the current requests, addresses and stall counter; no combinational dependency of ready on data_out.
REQ-012 SHALL return data for a read accepted in cycle N in cycle N+1, with rd_valid=1 for exactly that cycle.
REQ-013 SHALL hold data_out at its last read value while rd_valid=0.
REQ-014 SHALL make a write accepted in cycle N visible to a read accepted in cycle N+1 or later; no same-cycle forwarding.
REQ-015 SHALL increment conflict_cnt on every conflict cycle, saturating at 16'hFFFF.
REQ-016 SHALL ignore requests while they are not accepted; the requester holds req and addr until ready is seen.

Reset
REQ-017 SHALL, while rst_n=0, force:
- rd_valid=0, data_out=0, conflict_cnt=0, stall counter=0;
- wr_ready=0, rd_ready=0.
REQ-018 SHALL leave memory contents unchanged by reset.
REQ-019 SHALL, when reset is asserted while a read is in flight, drop that read: no rd_valid after rst_n deasserts.

Configuration
REQ-020 SHALL honour the macro RAM_GBUF_WMASK_EN:
- defined: a write updates only the bytes whose wr_mask bit is 1;
- undefined: wr_mask is ignored and every write updates the full word.

Structure
REQ-021 SHALL place bank-index width, row width and mask width derivation functions in shared package ram_gbuf_pkg.
REQ-022 SHALL instantiate NUM_BANKS copies of sub-module ram_gbuf_sp_bank, a single-port synchronous array with one-cycle read and optional byte mask; the arbiter and output mux/hold register stay in the top module.

Verification
REQ-023 SHALL cover a parallel access, NUM_BANKS=4: write addr_w=0x05 (bank 1) data 0xA5.. and read addr_r=0x02 (bank 2) in the same cycle -> wr_ready=1, rd_ready=1, rd_valid=1 next cycle.
REQ-024 SHALL cover a single conflict: wr_req and rd_req both to bank 3 -> rd_ready=0, wr_ready=1, conflict_cnt=1; read accepted next cycle once the write drops.
REQ-025 SHALL cover the starvation guard, MAX_RD_STALL=2: wr_req and rd_req held to the same bank for 4 cycles -> rd_ready pattern 0,0,1,0 and wr_ready pattern 1,1,0,1.
REQ-026 SHALL cover the byte mask with RAM_GBUF_WMASK_EN defined: write all-ones, then write 0 with mask 0x001, then read -> low byte 0x00, all other bytes 0xFF; without the macro, the read returns 0.
REQ-027 SHALL cover hold and reset: read returns 0x1234, then 5 idle cycles -> data_out stays 0x1234 with rd_valid=0; rst_n pulsed low while a read is in flight -> data_out=0, no rd_valid, memory still returns 0x1234 afterwards.
